// File: rtl/custom_sort_engine_pkg.sv
// Shared constants and helpers for the registered rank-and-scatter sorter.
// Imported by the rank sub-module and the top.
package sort_pkg;

    localparam int SORT_N     = 6;
    localparam int SORT_WIDTH = 8;

    function automatic int rank_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/custom_sort_engine_if.sv
// Input/result bundle of the sorter; the master presents vectors and the slave (the engine) returns them ordered.
interface custom_sort_engine_if #(
    parameter int N     = 6,
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic [WIDTH-1:0] data_in     [N];
    logic             out_valid;
    logic [WIDTH-1:0] data_sorted [N];

    modport master (
        output in_valid,
        output data_in,
        input  out_valid,
        input  data_sorted
    );

    modport slave (
        input  in_valid,
        input  data_in,
        output out_valid,
        output data_sorted
    );

endinterface

// File: rtl/custom_sort_engine_rank.sv
// Final position of one element within the array: strictly smaller elements
// plus equal elements at lower indices, so ties keep their input order.
module sort_rank
    import sort_pkg::*;
#(
    parameter  int N     = SORT_N,
    parameter  int WIDTH = SORT_WIDTH,
    localparam int RW    = rank_w(N)
) (
    input  logic [RW-1:0]    idx,
    input  logic [WIDTH-1:0] data [N],
    output logic [RW-1:0]    rank
);

    logic [WIDTH-1:0] mine;

    always_comb begin
        mine = '0;
        for (int k = 0; k < N; k++) begin
            if (RW'(k) == idx) begin
                mine = data[k];
            end
        end
    end

    always_comb begin
        rank = '0;
        for (int j = 0; j < N; j++) begin
            if (data[j] < mine) begin
                rank = rank + RW'(1);
            end else if ((data[j] == mine) && (RW'(j) < idx)) begin
                rank = rank + RW'(1);
            end
        end
    end

endmodule

// File: rtl/custom_sort_engine.sv
// Single-cycle sorting stage: ranks every element combinationally, scatters
// each into its ranked slot and registers the ordered vector.
module custom_sort_engine
    import sort_pkg::*;
#(
    parameter  int N     = SORT_N,
    parameter  int WIDTH = SORT_WIDTH,
    localparam int RW    = rank_w(N)
) (
    input  logic              clk,
    input  logic              rst,
    custom_sort_engine_if.slave bus
);

    logic [RW-1:0]    rank           [N];
    logic [WIDTH-1:0] sorted_comb    [N];
    logic [WIDTH-1:0] data_sorted_d  [N];
    logic [WIDTH-1:0] data_sorted_q  [N];
    logic             out_valid_d;
    logic             out_valid_q;

    for (genvar g = 0; g < N; g++) begin : g_rank
        sort_rank #(
            .N     (N),
            .WIDTH (WIDTH)
        ) u_rank (
            .idx  (RW'(g)),
            .data (bus.data_in),
            .rank (rank[g])
        );
    end

    // Ranks are unique, so exactly one element matches each slot.
    always_comb begin
        for (int s = 0; s < N; s++) begin
            sorted_comb[s] = '0;
            for (int i = 0; i < N; i++) begin
                if (rank[i] == RW'(s)) begin
                    sorted_comb[s] = bus.data_in[i];
                end
            end
        end
    end

    always_comb begin
        out_valid_d   = bus.in_valid;
        data_sorted_d = data_sorted_q;
        if (bus.in_valid) begin
            data_sorted_d = sorted_comb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                data_sorted_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
        end else begin
            data_sorted_q <= data_sorted_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.data_sorted = data_sorted_q;

endmodule

// File: tb/tb_custom_sort_engine.sv
// Directed table plus multi-cycle corner sequences and a random stream
// checked against an insertion-sort reference.
module tb_custom_sort_engine;

    localparam int N = 6;
    localparam int W = 8;
    localparam int NUM_TABLE = 7;

    typedef logic [N-1:0][W-1:0] arr_t;

    typedef struct packed {
        arr_t din;
        arr_t exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    vec_t vecs [NUM_TABLE];
    arr_t last_out;
    arr_t zeros;
    arr_t rnd;

    custom_sort_engine_if #(.N(N), .WIDTH(W)) bus ();

    custom_sort_engine #(.N(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic arr_t mk(input int a0, input int a1, input int a2,
                                input int a3, input int a4, input int a5);
        arr_t r;
        r[0] = W'(a0);
        r[1] = W'(a1);
        r[2] = W'(a2);
        r[3] = W'(a3);
        r[4] = W'(a4);
        r[5] = W'(a5);
        return r;
    endfunction

    function automatic arr_t ref_sort(input arr_t a);
        arr_t r;
        logic [W-1:0] t;
        r = a;
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0; j--) begin
                if (r[j-1] > r[j]) begin
                    t      = r[j];
                    r[j]   = r[j-1];
                    r[j-1] = t;
                end
            end
        end
        return r;
    endfunction

    task automatic apply_stimulus(input logic v, input arr_t d);
        bus.in_valid = v;
        for (int i = 0; i < N; i++) begin
            bus.data_in[i] = d[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic ev, input arr_t ed);
        arr_t got;
        for (int i = 0; i < N; i++) begin
            got[i] = bus.data_sorted[i];
        end
        n_vec++;
        if (bus.out_valid !== ev || got !== ed) begin
            n_err++;
            $display("[TB] FAIL %s: got out_valid=%b data(hi..lo)=%h, want out_valid=%b data(hi..lo)=%h",
                     name, bus.out_valid, got, ev, ed);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        zeros = '0;

        vecs[0] = '{din: mk(5, 0, 2, 1, 1, 3),         exp: mk(0, 1, 1, 2, 3, 5)};
        vecs[1] = '{din: mk(3, 2, 4, 0, 1, 5),         exp: mk(0, 1, 2, 3, 4, 5)};
        vecs[2] = '{din: mk(1, 1, 1, 1, 0, 2),         exp: mk(0, 1, 1, 1, 1, 2)};
        vecs[3] = '{din: mk(255, 0, 255, 128, 0, 1),   exp: mk(0, 0, 1, 128, 255, 255)};
        vecs[4] = '{din: mk(7, 7, 7, 7, 7, 7),         exp: mk(7, 7, 7, 7, 7, 7)};
        vecs[5] = '{din: mk(200, 100, 50, 25, 12, 6),  exp: mk(6, 12, 25, 50, 100, 200)};
        vecs[6] = '{din: mk(0, 255, 0, 255, 0, 255),   exp: mk(0, 0, 0, 255, 255, 255)};

        // Reset held two cycles with a valid vector present: it must be dropped.
        rst = 1'b1;
        apply_stimulus(1'b1, mk(9, 8, 7, 6, 5, 4));
        step();
        step();
        check_output("reset", 1'b0, zeros);
        rst = 1'b0;

        // Back-to-back valid vectors: each result lands the cycle after its input.
        for (int v = 0; v < NUM_TABLE; v++) begin
            apply_stimulus(1'b1, vecs[v].din);
            step();
            check_output($sformatf("table%0d", v), 1'b1, vecs[v].exp);
        end
        last_out = vecs[NUM_TABLE-1].exp;

        for (int h = 0; h < 3; h++) begin
            apply_stimulus(1'b0, mk(17 + h, 250, 3 * h, 99, 1, 42));
            step();
            check_output($sformatf("hold%0d", h), 1'b0, last_out);
        end

        apply_stimulus(1'b1, vecs[0].din);
        step();
        check_output("after_hold", 1'b1, vecs[0].exp);

        rst = 1'b1;
        apply_stimulus(1'b1, vecs[1].din);
        step();
        check_output("reset_override", 1'b0, zeros);
        rst = 1'b0;
        apply_stimulus(1'b1, vecs[3].din);
        step();
        check_output("post_reset", 1'b1, vecs[3].exp);

        for (int r = 0; r < 1000; r++) begin
            for (int i = 0; i < N; i++) begin
                rnd[i] = (r % 2 == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 7));
            end
            if (r == 500) begin
                rst = 1'b1;
                apply_stimulus(1'b1, rnd);
                step();
                check_output("mid_reset", 1'b0, zeros);
                rst = 1'b0;
            end else begin
                apply_stimulus(1'b1, rnd);
                step();
                check_output($sformatf("rand%0d", r), 1'b1, ref_sort(rnd));
            end
        end

        apply_stimulus(1'b0, zeros);
        step();
        check_output("final_drop", 1'b0, ref_sort(rnd));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
